sr_latch_ctrl: RTL and testbench
================================

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, meaning consecutive stable cycles needed to accept a button level (10 ms at 27 MHz).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the width of the latch-transition counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port btn1, input, 1 bit: raw reset-request button, active-low (0 = pressed), asynchronous to clk.
REQ-006 SHALL have port btn2, input, 1 bit: raw set-request button, active-low (0 = pressed), asynchronous to clk.
REQ-007 SHALL have port led, output, 6 bits, active-low: led[0]=~q, led[5]=~qn, led[4:1]=~cnt.

Function
REQ-008 SHALL pass each button through a 2-flop synchronizer before any other logic uses it.
REQ-009 SHALL debounce each synchronized button with its own counter:
- the counter runs while the synchronized level differs from the debounced level;
- it clears when the two levels match;
- when it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level updates on the next edge and the counter clears.
REQ-010 SHALL produce a one-cycle request (req_r from btn1, req_s from btn2) on each debounced 1->0 transition only; releases SHALL produce no request.
REQ-011 SHALL implement FSM states IDLE, APPLY_S, APPLY_R, FAULT and HOLD; the reset state is IDLE.
REQ-012 IDLE transitions:
- req_s alone -> APPLY_S;
- req_r alone -> APPLY_R;
- req_s and req_r in the same cycle -> FAULT;
- no request -> stay in IDLE.
REQ-013 APPLY_S SHALL last exactly one cycle: q<=1, qn<=0, then -> HOLD.
REQ-014 APPLY_R SHALL last exactly one cycle: q<=0, qn<=1, then -> HOLD.
REQ-015 FAULT SHALL last exactly one cycle: q<=1, qn<=1 (forbidden-state indication, both LEDs lit), then -> HOLD.
REQ-016 HOLD SHALL ignore all requests and return to IDLE only when both debounced buttons read released (1).
REQ-017 Timing of a request: a req_s/req_r asserted in cycle N SHALL be reflected on q/qn/led at the clock edge ending cycle N+1.
REQ-018 A request arriving while the FSM is not in IDLE SHALL be dropped, never queued.
REQ-019 An APPLY that leaves q unchanged (set while already set, reset while already reset) SHALL leave cnt unchanged.
REQ-020 The transition counter cnt SHALL:
- increment by 1 on every APPLY_S or APPLY_R that changes q;
- not increment on FAULT;
- wrap from 2^CNT_W-1 to 0.
REQ-021 The first valid APPLY after a FAULT SHALL restore q/qn to complementary values.
- A transition from the FAULT value (q=1) counts only if the new q differs from 1.
REQ-022 led SHALL be a pure inversion of registered values, with no combinational path from btn1/btn2.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL reset as follows:
- FSM -> IDLE;
- q=0, qn=1, cnt=0;
- synchronizer flops and debounced levels = 1 (released);
- debounce counters = 0.
REQ-024 The resulting led value after reset SHALL be 6'b011111.
REQ-025 rst SHALL take priority over every other event, including asserting it mid-APPLY, mid-HOLD or during a debounce count.
REQ-026 No request SHALL be generated in the first cycle after rst deasserts.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enumeration (IDLE, APPLY_S, APPLY_R, FAULT, HOLD);
- the DEBOUNCE_CYCLES default constant;
- the led bit-index constants.
REQ-028 The synchronizer plus debouncer plus edge detector SHALL be one sub-module, btn_debounce, instantiated once per button; the FSM, latch registers and counter SHALL live in sr_latch_ctrl.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset: hold rst 2 cycles -> led=6'b011111 and FSM=IDLE.
REQ-030 Set: btn2 low for 10 cycles, then high -> exactly one req_s; q=1, qn=0, cnt=1, led=6'b111100.
- The FSM stays in HOLD until btn2 is released, then returns to IDLE.
REQ-031 Bounce rejection: btn2 toggled every 2 cycles for 20 cycles -> no request, led unchanged.
REQ-032 Simultaneous press: btn1 and btn2 driven low in the same cycle for 10 cycles -> FAULT; led[0]=0, led[5]=0, cnt unchanged.
- A subsequent btn1 press after both are released -> q=0, qn=1.
REQ-033 Wrap and redundant presses: 16 alternating set/reset presses -> cnt wraps to 0.
- A set press while q=1 leaves cnt unchanged.
REQ-034 Reset mid-operation: assert rst in the APPLY_S cycle -> next cycle q=0, cnt=0, FSM=IDLE; no pending request is executed afterward.

Source files
------------

// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types and constants for the button-driven SR latch controller.
// Holds the FSM state encoding, the default debounce length and the LED bit map.
package sr_latch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY_S = 3'd1,
        APPLY_R = 3'd2,
        FAULT   = 3'd3,
        HOLD    = 3'd4
    } state_t;

    // 10 ms of stable input at 27 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 270000;

    localparam int LED_Q_IDX   = 0;
    localparam int LED_CNT_LSB = 1;
    localparam int LED_CNT_MSB = 4;
    localparam int LED_CNT_W   = LED_CNT_MSB - LED_CNT_LSB + 1;
    localparam int LED_QN_IDX  = 5;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes and debounces one active-low button, and emits a one-cycle
// pulse when the debounced level falls (press); releases produce nothing.
module btn_debounce
    import sr_latch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic fall
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            level_q  <= 1'b1;
            fall_q   <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            fall_q   <= fall_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/sr_latch_ctrl.sv
// SR latch emulation driven by two debounced push buttons (btn2 = set,
// btn1 = reset), with a counter of q transitions shown on active-low LEDs.
module sr_latch_ctrl
    import sr_latch_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    output logic [5:0] led
);

    logic             level_r, level_s;
    logic             req_r, req_s;
    state_t           state_q, state_d;
    logic             q_q, q_d;
    logic             qn_q, qn_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn1),
        .level (level_r),
        .fall  (req_r)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_s (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn2),
        .level (level_s),
        .fall  (req_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only looked at in IDLE, so anything arriving later is lost.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_s && req_r) begin
                    state_d = FAULT;
                end else if (req_s) begin
                    state_d = APPLY_S;
                end else if (req_r) begin
                    state_d = APPLY_R;
                end
            end
            APPLY_S, APPLY_R, FAULT: state_d = HOLD;
            HOLD: begin
                if (level_r && level_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counting keys off the current q, so leaving FAULT (q=1) via a set
    // does not count while leaving it via a reset does.
    always_comb begin
        q_d   = q_q;
        qn_d  = qn_q;
        cnt_d = cnt_q;
        case (state_q)
            APPLY_S: begin
                q_d  = 1'b1;
                qn_d = 1'b0;
                if (!q_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            APPLY_R: begin
                q_d  = 1'b0;
                qn_d = 1'b1;
                if (q_q) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                q_d  = 1'b1;
                qn_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= 1'b0;
            qn_q  <= 1'b1;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            qn_q  <= qn_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        led                            = '0;
        led[LED_Q_IDX]                 = ~q_q;
        led[LED_QN_IDX]                = ~qn_q;
        led[LED_CNT_MSB:LED_CNT_LSB]   = ~LED_CNT_W'(cnt_q);
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl: a cycle-level behavioural model checked on every
// cycle, plus hand-computed LED/state expectations at key points.
module tb_sr_latch_ctrl;
    import sr_latch_ctrl_pkg::*;

    localparam int DC    = 4;
    localparam int CNT_W = 4;
    localparam int HIST  = DC + 2;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       btn1 = 1'b1;
    logic       btn2 = 1'b1;
    logic [5:0] led;

    int checks     = 0;
    int passed     = 0;
    int req_s_seen = 0;

    sr_latch_ctrl #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .btn1 (btn1),
        .btn2 (btn2),
        .led  (led)
    );

    always #5 clk = ~clk;

    // Model: index 0 = btn1 (reset request), 1 = btn2 (set request).
    // hist[b][j] is the raw level sampled j edges ago; the latch sees a button
    // two edges late and accepts a new level once DC such samples all disagree.
    bit m_hist[2][HIST];
    bit m_lvl[2];
    bit m_req[2];
    bit raw_v[2];
    int m_action;
    bit m_hold;
    bit m_q, m_qn;
    int m_cnt;
    bit m_valid = 1'b0;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < HIST; j++) m_hist[b][j] = 1'b1;
            m_lvl[b] = 1'b1;
            m_req[b] = 1'b0;
        end
        m_action = 0;
        m_hold   = 1'b0;
        m_q      = 1'b0;
        m_qn     = 1'b1;
        m_cnt    = 0;
    endtask

    function automatic logic [5:0] model_led();
        logic [3:0] c;
        c = m_cnt[3:0];
        return ~{m_qn, c, m_q};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            m_valid = 1'b1;
        end else begin
            raw_v[0] = btn1;
            raw_v[1] = btn2;
            if (m_action == 1) begin
                if (!m_q) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_q = 1'b1; m_qn = 1'b0;
                m_action = 0; m_hold = 1'b1;
            end else if (m_action == 2) begin
                if (m_q) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_q = 1'b0; m_qn = 1'b1;
                m_action = 0; m_hold = 1'b1;
            end else if (m_action == 3) begin
                m_q = 1'b1; m_qn = 1'b1;
                m_action = 0; m_hold = 1'b1;
            end else if (m_hold) begin
                if (m_lvl[0] && m_lvl[1]) m_hold = 1'b0;
            end else if (m_req[0] && m_req[1]) begin
                m_action = 3;
            end else if (m_req[1]) begin
                m_action = 1;
            end else if (m_req[0]) begin
                m_action = 2;
            end
            for (int b = 0; b < 2; b++) begin
                bit all_differ;
                for (int j = HIST - 1; j > 0; j--) m_hist[b][j] = m_hist[b][j-1];
                m_hist[b][0] = raw_v[b];
                all_differ = 1'b1;
                for (int j = 2; j < HIST; j++) begin
                    if (m_hist[b][j] == m_lvl[b]) all_differ = 1'b0;
                end
                if (all_differ) begin
                    m_req[b] = m_lvl[b];
                    m_lvl[b] = ~m_lvl[b];
                end else begin
                    m_req[b] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) check_output("led_vs_model", {26'd0, led}, {26'd0, model_led()});
        if (dut.req_s === 1'b1) req_s_seen++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic b1, input logic b2, input int n);
        btn1 = b1;
        btn2 = b2;
        wait_cycles(n);
    endtask

    task automatic press(input bit set_btn);
        if (set_btn) apply_stimulus(1'b1, 1'b0, 10);
        else         apply_stimulus(1'b0, 1'b1, 10);
        apply_stimulus(1'b1, 1'b1, 12);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check_output("reset_led", {26'd0, led}, 32'h1F);
        check_output("reset_state", 32'(dut.state_q), 32'(IDLE));
        wait_cycles(3);
        check_output("no_req_after_reset", req_s_seen, 0);

        // Set press: HOLD while held, IDLE after release.
        req_s_seen = 0;
        apply_stimulus(1'b1, 1'b0, 10);
        check_output("set_hold_state", 32'(dut.state_q), 32'(HOLD));
        check_output("set_led", {26'd0, led}, 32'h3C);
        apply_stimulus(1'b1, 1'b1, 12);
        check_output("set_idle_state", 32'(dut.state_q), 32'(IDLE));
        check_output("set_one_req", req_s_seen, 1);

        req_s_seen = 0;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'(i % 2), 2);
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("bounce_no_req", req_s_seen, 0);
        check_output("bounce_led", {26'd0, led}, 32'h3C);

        apply_stimulus(1'b0, 1'b0, 10);
        check_output("fault_led", {26'd0, led}, 32'h1C);
        check_output("fault_state", 32'(dut.state_q), 32'(HOLD));
        apply_stimulus(1'b1, 1'b1, 12);
        press(1'b0);
        check_output("after_fault_reset_led", {26'd0, led}, 32'h1B);
        press(1'b0);
        check_output("redundant_reset_led", {26'd0, led}, 32'h1B);

        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        check_output("rst_before_wrap_led", {26'd0, led}, 32'h1F);
        for (int i = 0; i < 16; i++) begin
            press(i % 2 == 0);
            if (i == 14) check_output("cnt15_led", {26'd0, led}, 32'h20);
        end
        check_output("wrap_led", {26'd0, led}, 32'h1F);
        press(1'b1);
        check_output("set_after_wrap_led", {26'd0, led}, 32'h3C);
        press(1'b1);
        check_output("redundant_set_led", {26'd0, led}, 32'h3C);

        // Reset asserted during the APPLY_S cycle.
        btn2 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            wait_cycles(1);
            if (dut.state_q == APPLY_S) found = 1'b1;
        end
        check_output("apply_s_seen", 32'(found), 32'd1);
        rst  = 1'b1;
        btn2 = 1'b1;
        wait_cycles(1);
        check_output("mid_apply_rst_led", {26'd0, led}, 32'h1F);
        check_output("mid_apply_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        wait_cycles(15);
        check_output("post_rst_led", {26'd0, led}, 32'h1F);
        check_output("post_rst_state", 32'(dut.state_q), 32'(IDLE));

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
